// File: rtl/fwrisc_dbus_mmio_target.sv
// fwrisc_dbus_mmio_target
// Data-bus target for the FWRISC core data port. Each request is decoded to
// either the byte-enabled synchronous SRAM or a small MMIO register file
// (tohost status, console output, optional 64-bit machine timer).
// Each request takes two cycles: an accept cycle followed by an ACK cycle
// that pulses dready.
//
// Optional feature macro: FWRISC_DBUS_MMIO_TIMER_EN
//   defined   -> mtime / mtimecmp registers and the timer irq are built
//   undefined -> timer offsets read 0 and ignore writes, irq tied to 0
//
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   daddr/dwdata/dwstb    : core request address, write data, byte strobes
//   dwrite/dvalid         : core request direction and valid
//   dready/drdata         : completion pulse and read data (ACK cycle)
//   m_adr/m_dat_w/m_we    : SRAM word address, write data, write enable
//   m_sel/m_dat_r         : SRAM byte selects, read data (1-cycle latency)
//   irq                   : timer interrupt
//   console_valid/_data   : console byte output
//   test_done/test_pass   : sticky test status from tohost writes
module fwrisc_dbus_mmio_target #(
  parameter logic [31:0] MMIO_BASE      = 32'h8000_0000,
  parameter int unsigned SRAM_ADR_WIDTH = 22
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               daddr,
  input  logic [31:0]               dwdata,
  input  logic [3:0]                dwstb,
  input  logic                      dwrite,
  input  logic                      dvalid,
  output logic                      dready,
  output logic [31:0]               drdata,
  output logic [SRAM_ADR_WIDTH-1:0] m_adr,
  output logic [31:0]               m_dat_w,
  output logic                      m_we,
  output logic [3:0]                m_sel,
  input  logic [31:0]               m_dat_r,
  output logic                      irq,
  output logic                      console_valid,
  output logic [7:0]                console_data,
  output logic                      test_done,
  output logic                      test_pass
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  localparam logic [7:0] OFF_TOHOST   = 8'h00;
  localparam logic [7:0] OFF_CONSOLE  = 8'h04;
  localparam logic [7:0] OFF_MTIME_LO = 8'h08;
  localparam logic [7:0] OFF_MTIME_HI = 8'h0C;
  localparam logic [7:0] OFF_CMP_LO   = 8'h10;
  localparam logic [7:0] OFF_CMP_HI   = 8'h14;

  logic [0:0]  state;
  logic [0:0]  state_nxt;
  logic        accept_c;
  logic        is_mmio_c;
  logic        mmio_wr_c;
  logic [7:0]  offset_c;
  logic [31:0] mmio_rd_c;
  logic        sel_mmio_q;
  logic [31:0] mmio_rdata_q;
  logic [31:0] tohost_q;
  logic        unused_addr_c;

  assign unused_addr_c = ^daddr[1:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; accept_c marks the cycle a request is taken
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      IDLE: begin
        if (dvalid) begin
          state_nxt = ACK;
          accept_c  = 1'b1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address decode
  assign is_mmio_c = (daddr[31:16] == MMIO_BASE[31:16]);
  assign offset_c  = daddr[7:0];
  assign mmio_wr_c = accept_c & is_mmio_c & dwrite;

  // SRAM side is a straight pass-through; write enable only in the accept cycle
  assign m_adr   = daddr[SRAM_ADR_WIDTH+1:2];
  assign m_dat_w = dwdata;
  assign m_sel   = dwstb;
  assign m_we    = accept_c & dwrite & ~is_mmio_c & ~reset;

  // Response: SRAM data arrives in ACK, MMIO data was captured at accept
  assign dready = (state == ACK);
  assign drdata = dready ? (sel_mmio_q ? mmio_rdata_q : m_dat_r) : 32'h0;

`ifdef FWRISC_DBUS_MMIO_TIMER_EN
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [63:0] mtime_nxt_c;
  logic [63:0] mtimecmp_nxt_c;
  logic        irq_q;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  stb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = stb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  // A write to either mtime half replaces the increment for that cycle
  always_comb begin
    mtime_nxt_c    = mtime + 64'd1;
    mtimecmp_nxt_c = mtimecmp;
    if (mmio_wr_c) begin
      case (offset_c)
        OFF_MTIME_LO: mtime_nxt_c = {mtime[63:32], byte_merge(mtime[31:0], dwdata, dwstb)};
        OFF_MTIME_HI: mtime_nxt_c = {byte_merge(mtime[63:32], dwdata, dwstb), mtime[31:0]};
        OFF_CMP_LO:   mtimecmp_nxt_c = {mtimecmp[63:32], byte_merge(mtimecmp[31:0], dwdata, dwstb)};
        OFF_CMP_HI:   mtimecmp_nxt_c = {byte_merge(mtimecmp[63:32], dwdata, dwstb), mtimecmp[31:0]};
        default: ;
      endcase
    end
  end

  // Timer registers; irq compares current values so it lags updates by one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      mtime    <= 64'h0;
      mtimecmp <= '1;
      irq_q    <= 1'b0;
    end else begin
      mtime    <= mtime_nxt_c;
      mtimecmp <= mtimecmp_nxt_c;
      irq_q    <= (mtime >= mtimecmp);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // MMIO read mux
  always_comb begin
    mmio_rd_c = 32'h0;
    case (offset_c)
      OFF_TOHOST:   mmio_rd_c = tohost_q;
`ifdef FWRISC_DBUS_MMIO_TIMER_EN
      OFF_MTIME_LO: mmio_rd_c = mtime[31:0];
      OFF_MTIME_HI: mmio_rd_c = mtime[63:32];
      OFF_CMP_LO:   mmio_rd_c = mtimecmp[31:0];
      OFF_CMP_HI:   mmio_rd_c = mtimecmp[63:32];
`endif
      default:      mmio_rd_c = 32'h0;
    endcase
  end

  // Accept-time capture, console and tohost status
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_mmio_q    <= 1'b0;
      mmio_rdata_q  <= 32'h0;
      tohost_q      <= 32'h0;
      console_valid <= 1'b0;
      console_data  <= 8'h0;
      test_done     <= 1'b0;
      test_pass     <= 1'b0;
    end else begin
      console_valid <= 1'b0;
      if (accept_c) begin
        sel_mmio_q   <= is_mmio_c;
        mmio_rdata_q <= mmio_rd_c;
      end
      if (mmio_wr_c && offset_c == OFF_TOHOST) begin
        tohost_q  <= dwdata;
        test_done <= 1'b1;
        test_pass <= (dwdata == 32'd1);
      end
      if (mmio_wr_c && offset_c == OFF_CONSOLE && dwstb[0]) begin
        console_valid <= 1'b1;
        console_data  <= dwdata[7:0];
      end
    end
  end

endmodule

// File: doc/fwrisc_dbus_mmio_target.md
# fwrisc_dbus_mmio_target

Data-bus target for the FWRISC RV32I core's data port, placed directly downstream of the core in the unit-level bench and in small integrations. Decodes each core data request and forwards it either to the byte-enabled synchronous SRAM or to a small MMIO register file. The MMIO file holds a test-status (tohost) register, a console output port and an optional 64-bit machine timer that drives the core's `irq` input.

## Interface
Parameters:
- `MMIO_BASE`, default `32'h8000_0000`: base of the MMIO window. Requests with `daddr[31:16] == MMIO_BASE[31:16]` go to MMIO; all other requests go to SRAM.
- `SRAM_ADR_WIDTH`, default 22: SRAM word-address width.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `daddr` in 32: core request byte address.
- `dwdata` in 32: core write data.
- `dwstb` in 4: byte write strobes.
- `dwrite` in 1: 1 = write, 0 = read.
- `dvalid` in 1: core request valid; held until `dready`.
- `dready` out 1: one-cycle completion pulse.
- `drdata` out 32: read data; valid when `dready`=1.
- `m_adr` out `SRAM_ADR_WIDTH`: SRAM word address, `daddr[SRAM_ADR_WIDTH+1:2]`.
- `m_dat_w` out 32: SRAM write data, equal to `dwdata`.
- `m_we` out 1: SRAM write enable.
- `m_sel` out 4: SRAM byte selects, equal to `dwstb`.
- `m_dat_r` in 32: SRAM read data, registered by the SRAM with 1-cycle latency.
- `irq` out 1: timer interrupt to the core.
- `console_valid` out 1: one-cycle pulse when a console byte is written.
- `console_data` out 8: console byte; valid with `console_valid`.
- `test_done` out 1: sticky; set on any tohost write.
- `test_pass` out 1: sticky; valid when `test_done`=1.

## Operation
- FSM states: IDLE, ACK.
- IDLE → ACK when `dvalid`=1. This is the accept cycle:
  - SRAM target: `m_we` = `dwrite`, only during this cycle.
  - MMIO target: write performed, or read data registered.
- ACK → IDLE unconditionally, with `dready`=1 for this one cycle.
- `drdata` in ACK:
  - SRAM target: `m_dat_r`.
  - MMIO target: the registered MMIO read value.
  - The read mux select is registered at accept.
- MMIO offsets (`daddr[7:0]`):
  - 0x00 TOHOST: write sets `test_done`. `test_pass` = (`dwdata` == 1). Reads return the last written value.
  - 0x04 CONSOLE: write with `dwstb[0]` pulses `console_valid` in ACK, with `console_data` = `dwdata[7:0]`. Reads return 0.
  - 0x08/0x0C MTIME lo/hi; 0x10/0x14 MTIMECMP lo/hi. Writes honour `dwstb` per byte.
  - All other offsets: reads return 0, writes are ignored, and the request is still acknowledged.
- `test_done` and `test_pass` are held until reset. A later tohost write overwrites both.
- Timer:
  - `mtime` increments by 1 every cycle outside reset.
  - A write to MTIME takes priority over that cycle's increment. Only the written half and bytes are replaced.
  - `irq` is registered: `irq` = (`mtime` >= `mtimecmp`), 64-bit unsigned, recomputed every cycle.
  - `mtime` wraps 2^64−1 → 0.

## Timing
- Reset values:
  - State IDLE.
  - `dready`, `m_we`, `irq`, `console_valid`, `test_done`, `test_pass` = 0.
  - `drdata` = 0, `console_data` = 0.
  - `mtime` = 0, `mtimecmp` = all ones.
- Latency: accept at cycle N, `dready` at N+1. The next accept is possible at N+2, so throughput is 1 request per 2 cycles.
- `dvalid` still high at N+2 is treated as a new request.
- `m_adr`, `m_dat_w` and `m_sel` are combinational from the core inputs.
- An `irq` change appears 1 cycle after the `mtime`/`mtimecmp` update.
- Reset asserted during ACK: `dready` drops the same edge and the state returns to IDLE. An SRAM write issued at accept is not undone.

## Configuration
- `FWRISC_DBUS_MMIO_TIMER_EN` defined: `mtime`, `mtimecmp` and `irq` are implemented as above.
- Not defined:
  - Timer registers are absent; offsets 0x08–0x14 read 0 and ignore writes.
  - `irq` is tied to 0.
  - The rest of the behaviour is unchanged.

## Test plan
- Write `0xDEADBEEF` to 0x100 with `dwstb`=0xF, then read 0x100. Required: `m_we` pulses for 1 cycle, `dready` is 1 cycle after each accept, and the read returns `0xDEADBEEF`.
- Write to 0x104 with `dwstb`=0x2 and `dwdata`=0x0000AB00 over a word containing `0x11223344`. Required: the read returns `0x1122AB44`.
- Write 'A' (0x41) to `MMIO_BASE`+4. Required: `console_valid` is 1 for exactly 1 cycle with `console_data`=0x41. Then write 1 to `MMIO_BASE`+0. Required: `test_done`=1 and `test_pass`=1. A subsequent write of 3 gives `test_pass`=0.
- With the timer enabled, write `mtimecmp` = `mtime`+20. Required: `irq` rises within 20–22 cycles. Writing `mtimecmp` hi = 0xFFFFFFFF clears `irq` 1 cycle later.
- With the timer enabled, write `mtime` = 0xFFFFFFFF_FFFFFFFE. Required: it wraps to 0 two cycles later. Read `MMIO_BASE`+0x20. Required: returns 0 and `dready` still pulses.
- Assert `reset` in an ACK cycle. Required: `dready`=0 on the next edge, the state returns to IDLE, and all status outputs are 0.
